muldiv_unit: RTL

//  Iterative multiply/divide unit consuming the two register-file read buses (busA, busB).

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO result registers.
// Optional feature: define MULDIV_DZ_EN to add the divZero status output.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             hiWr,
  input  logic             loWr,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
`ifdef MULDIV_DZ_EN
  output logic             divZero,
`endif
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 divOp_q, divOp_d;
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
  logic                 zeroB_q, zeroB_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand conditioning at the start edge: magnitudes plus result signs.
  logic             isSigned, negA, negB;
  logic [WIDTH-1:0] magA, magB;

  assign isSigned = ~op[0];
  assign negA     = isSigned & busA[WIDTH-1];
  assign negB     = isSigned & busB[WIDTH-1];
  assign magA     = negA ? -busA : busA;
  assign magB     = negB ? -busB : busB;

  // Multiply step: add multiplicand on LSB, shift the accumulator right.
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;

  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mulNext = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: accumulator is {remainder, dividend/quotient}.
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] divNext;

  assign shifted = {acc_q, 1'b0};
  assign diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
  assign divNext = diff[WIDTH+1] ? shifted[2*WIDTH-1:0]
                                 : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  assign prodFix = negRes_q ? -acc_q : acc_q;
  assign quotFix = zeroB_q ? '1 : (negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    divOp_d  = divOp_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    zeroB_d  = zeroB_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          divOp_d  = op[1];
          negRes_d = negA ^ negB;
          negRem_d = negA;
          zeroB_d  = (busB == '0);
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
          opnd_d   = op[1] ? magB : magA;
        end else begin
          if (hiWr) hi_d = busA;
          if (loWr) lo_d = busA;
        end
      end
      RUN: begin
        acc_d = divOp_q ? divNext : mulNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (divOp_q) begin
          hi_d = remFix;
          lo_d = quotFix;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      divOp_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      zeroB_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      divOp_q  <= divOp_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      zeroB_q  <= zeroB_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

`ifdef MULDIV_DZ_EN
  logic dz_q;

  // Sticky until the next accepted start; updated as the result is written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dz_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      dz_q <= 1'b0;
    end else if (state_q == FIX) begin
      dz_q <= divOp_q & zeroB_q;
    end
  end

  assign divZero = dz_q;
`endif

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
